// File: rtl/uart_frame_decoder_pkg.sv
// Shared definitions for the framed-message decoder: state encoding,
// default framing bytes and the error-code bit positions.
package uart_frame_decoder_pkg;

  // One-hot frame-decoder states
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_BCNT = 5'b00010,
    ST_BODY = 5'b00100,
    ST_CSUM = 5'b01000,
    ST_DONE = 5'b10000
  } state_e;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'h7E;
  localparam logic [7:0] DEF_ESC_BYTE  = 8'hFE;

  // Bit positions inside the internal error vector
  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_TIMEOUT  = 1;
  localparam int ERR_CHECKSUM = 2;
  localparam int ERR_DROP     = 3;
  localparam int ERR_W        = 4;

  // State entered once the payload is complete (or N = 0)
  function automatic state_e after_payload(input bit checksum_en);
    if (checksum_en) begin
      return ST_CSUM;
    end else begin
      return ST_DONE;
    end
  endfunction

endpackage

// File: rtl/uart_frame_decoder_timeout.sv
// Inter-byte idle counter. Counts while enabled, clears on clr_i or when
// disabled, and flags the edge on which the count would reach TIMEOUT_CYCLES.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == TC_VAL);

  // Next count: restart on clear, disable or terminal count, else advance
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || tc_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Framed-message decoder: strips SYNC/ESC framing from a byte stream, checks
// length and optional XOR checksum, and holds the payload for a valid/ready
// consumer. Errors are reported as registered one-cycle pulses.
module uart_frame_decoder
  import uart_frame_decoder_pkg::*;
#(
  parameter int         MAX_BYTES      = 16,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0] ESC_BYTE       = DEF_ESC_BYTE,
  parameter int         CHECKSUM_EN    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  input  logic [7:0]             in_data_i,
  input  logic                   msg_ready_i,
  output logic                   msg_valid_o,
  output logic [7:0]             msg_len_o,
  output logic [8*MAX_BYTES-1:0] msg_data_o,
  output logic                   busy_o,
  output logic                   err_overflow_o,
  output logic                   err_timeout_o,
  output logic                   err_checksum_o,
  output logic                   err_drop_o
);

  localparam logic [7:0] MAX_B  = 8'(MAX_BYTES);
  localparam bit         CSUM_ON = (CHECKSUM_EN != 0);

  state_e                        state_q, state_d;
  logic                          esc_q, esc_d;
  logic [7:0]                    len_q, len_d;
  logic [7:0]                    idx_q, idx_d;
  logic [7:0]                    acc_q, acc_d;
  logic [MAX_BYTES-1:0][7:0]     data_q, data_d;
  logic [ERR_W-1:0]              err_q, err_d;

  logic   busy_s;
  logic   tmo_s;
  logic   tmo_clr_s;
  state_e eff_state_s;

  assign busy_s    = (state_q == ST_BCNT) || (state_q == ST_BODY) || (state_q == ST_CSUM);
  assign tmo_clr_s = in_valid_i;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (tmo_clr_s),
    .en_i  (busy_s),
    .tc_o  (tmo_s)
  );

  // Next-state, payload capture and error selection
  always_comb begin
    state_d     = state_q;
    esc_d       = esc_q;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    data_d      = data_q;
    err_d       = '0;
    // A handshaking DONE behaves like IDLE for any byte arriving with it
    eff_state_s = (state_q == ST_DONE) ? ST_IDLE : state_q;

    if (tmo_s) begin
      state_d             = ST_IDLE;
      esc_d               = 1'b0;
      err_d[ERR_TIMEOUT]  = 1'b1;
    end else if ((state_q == ST_DONE) && !msg_ready_i) begin
      // Message held: incoming bytes are dropped, escape state untouched
      if (in_valid_i) begin
        err_d[ERR_DROP] = 1'b1;
      end else begin
        err_d = '0;
      end
    end else begin
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end

      if (in_valid_i) begin
        if (!esc_q && (in_data_i == ESC_BYTE)) begin
          esc_d = 1'b1;
        end else if (!esc_q && (in_data_i == SYNC_BYTE)) begin
          data_d  = '0;
          idx_d   = 8'd0;
          acc_d   = 8'd0;
          len_d   = 8'd0;
          state_d = ST_BCNT;
        end else begin
          esc_d = 1'b0;
          case (eff_state_s)
            ST_BCNT: begin
              acc_d = in_data_i;
              if (in_data_i > MAX_B) begin
                err_d[ERR_OVERFLOW] = 1'b1;
                state_d             = ST_IDLE;
              end else if (in_data_i == 8'd0) begin
                len_d   = in_data_i;
                state_d = after_payload(CSUM_ON);
              end else begin
                len_d   = in_data_i;
                state_d = ST_BODY;
              end
            end
            ST_BODY: begin
              for (int i = 0; i < MAX_BYTES; i++) begin
                if (idx_q == 8'(i)) begin
                  data_d[i] = in_data_i;
                end else begin
                  data_d[i] = data_q[i];
                end
              end
              idx_d = idx_q + 8'd1;
              acc_d = acc_q ^ in_data_i;
              if (idx_q == (len_q - 8'd1)) begin
                state_d = after_payload(CSUM_ON);
              end else begin
                state_d = ST_BODY;
              end
            end
            ST_CSUM: begin
              if (in_data_i == acc_q) begin
                state_d = ST_DONE;
              end else begin
                err_d[ERR_CHECKSUM] = 1'b1;
                state_d             = ST_IDLE;
              end
            end
            default: begin
              // IDLE: literal or escaped bytes outside a frame are discarded
              state_d = ST_IDLE;
            end
          endcase
        end
      end else begin
        esc_d = esc_q;
      end
    end
  end

  // State, payload and error pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      esc_q   <= 1'b0;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      acc_q   <= 8'd0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      esc_q   <= esc_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign msg_valid_o    = (state_q == ST_DONE);
  assign busy_o         = busy_s;
  assign msg_len_o      = len_q;
  assign msg_data_o     = data_q;
  assign err_overflow_o = err_q[ERR_OVERFLOW];
  assign err_timeout_o  = err_q[ERR_TIMEOUT];
  assign err_checksum_o = err_q[ERR_CHECKSUM];
  assign err_drop_o     = err_q[ERR_DROP];

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder with hand-computed expectations.
module tb_uart_frame_decoder;

  localparam int MAXB = 16;
  localparam int TMO  = 20;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              msg_ready = 1'b0;
  logic              msg_valid;
  logic [7:0]        msg_len;
  logic [8*MAXB-1:0] msg_data;
  logic              busy;
  logic              e_ovf, e_tmo, e_cs, e_drop;
  logic [3:0]        errs;

  int cmp_cnt = 0;
  int err_cnt = 0;

  assign errs = {e_ovf, e_tmo, e_cs, e_drop};

  uart_frame_decoder #(
    .MAX_BYTES(MAXB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_data_i(in_data),
    .msg_ready_i(msg_ready), .msg_valid_o(msg_valid), .msg_len_o(msg_len),
    .msg_data_o(msg_data), .busy_o(busy), .err_overflow_o(e_ovf),
    .err_timeout_o(e_tmo), .err_checksum_o(e_cs), .err_drop_o(e_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte strobe from a negedge; returns at the following negedge
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic handshake();
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", 128'(msg_valid), 128'd0);
    chk("rst_len",   128'(msg_len),   128'd0);
    chk("rst_data",  msg_data,        128'd0);
    chk("rst_busy",  128'(busy),      128'd0);
    chk("rst_errs",  128'(errs),      128'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Frame 7E 03 11 22 33, checksum 03^11^22^33 = 03
    send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("f1_busy_pre",  128'(busy),      128'd1);
    chk("f1_valid_pre", 128'(msg_valid), 128'd0);
    send(8'h03);
    chk("f1_valid", 128'(msg_valid), 128'd1);
    chk("f1_len",   128'(msg_len),   128'd3);
    chk("f1_data",  msg_data,        128'h332211);
    chk("f1_busy",  128'(busy),      128'd0);

    // Bytes while held: dropped with err_drop, data unchanged
    send(8'h55);
    chk("drop1_err",  128'(errs),     128'b0001);
    chk("drop1_data", msg_data,       128'h332211);
    send(8'hFE);
    chk("drop2_err",  128'(errs),     128'b0001);
    chk("drop2_valid",128'(msg_valid),128'd1);
    @(negedge clk);
    chk("drop_clear", 128'(errs),     128'd0);
    handshake();
    chk("f1_ack", 128'(msg_valid), 128'd0);

    // Escaped payload 7E FE, checksum 02^7E^FE = 82
    send(8'h7E); send(8'h02); send(8'hFE); send(8'h7E); send(8'hFE); send(8'hFE);
    send(8'h82);
    chk("esc_valid", 128'(msg_valid), 128'd1);
    chk("esc_len",   128'(msg_len),   128'd2);
    chk("esc_data",  msg_data,        128'hFE7E);
    chk("esc_errs",  128'(errs),      128'd0);
    handshake();

    // Length 17 > MAX_BYTES
    send(8'h7E); send(8'h11);
    chk("ovf_err",  128'(errs), 128'b1000);
    chk("ovf_busy", 128'(busy), 128'd0);
    @(negedge clk);
    chk("ovf_pulse1", 128'(errs), 128'd0);
    send(8'h7E); send(8'h01); send(8'hA5); send(8'hA4);
    chk("post_ovf_valid", 128'(msg_valid), 128'd1);
    chk("post_ovf_data",  msg_data,        128'hA5);

    // SYNC together with msg_ready goes straight to BCNT
    msg_ready = 1'b1;
    send(8'h7E);
    msg_ready = 1'b0;
    chk("sync_rdy_valid", 128'(msg_valid), 128'd0);
    chk("sync_rdy_busy",  128'(busy),      128'd1);
    chk("sync_rdy_data",  msg_data,        128'd0);
    // N = 0 frame: checksum is just 00
    send(8'h00); send(8'h00);
    chk("zero_valid", 128'(msg_valid), 128'd1);
    chk("zero_len",   128'(msg_len),   128'd0);
    handshake();

    // Corrupted checksum: 02^10^20 = 32, send 33
    send(8'h7E); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    chk("cs_err",   128'(errs),      128'b0010);
    chk("cs_valid", 128'(msg_valid), 128'd0);
    @(negedge clk);
    chk("cs_valid2", 128'(msg_valid), 128'd0);

    // Timeout after TMO idle cycles
    send(8'h7E); send(8'h04); send(8'hAA);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_early_err",  128'(errs), 128'd0);
    chk("tmo_early_busy", 128'(busy), 128'd1);
    @(negedge clk);
    chk("tmo_err",  128'(errs), 128'b0100);
    chk("tmo_busy", 128'(busy), 128'd0);

    // Mid-frame SYNC restarts silently; 02^01^02 = 01
    send(8'h7E); send(8'h04); send(8'hAA); send(8'hBB);
    send(8'h7E);
    chk("restart_errs", 128'(errs), 128'd0);
    send(8'h02); send(8'h01); send(8'h02); send(8'h01);
    chk("restart_valid", 128'(msg_valid), 128'd1);
    chk("restart_data",  msg_data,        128'h0201);
    chk("restart_errs2", 128'(errs),      128'd0);
    handshake();

    // Asynchronous reset in BODY
    send(8'h7E); send(8'h05); send(8'h01); send(8'h02);
    chk("body_len", 128'(msg_len), 128'd5);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_len",  128'(msg_len),   128'd0);
    chk("arst_data", msg_data,        128'd0);
    chk("arst_busy", 128'(busy),      128'd0);
    chk("arst_valid",128'(msg_valid), 128'd0);
    chk("arst_errs", 128'(errs),      128'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
